// File: rtl/cpu_axi_rd_arbiter.sv
// rtl/cpu_axi_rd_arbiter.sv - two-requester AXI read arbiter, one outstanding read
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-over-inst priority.
module cpu_axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic        sel_data;
  logic        grant_any;
  logic        grant_data;
  logic        beat_hit;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_data;
`endif

  // Grant is combinational so addr_ok lands in the same cycle as req; rst gating
  // keeps addr_ok low while reset is held even though state already reads IDLE.
  always_comb begin
    grant_any = !rst && (state == IDLE) && (inst_req || data_req);
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req && data_req)
      grant_data = !last_data;
    else
      grant_data = data_req;
`else
    grant_data = data_req;
`endif
  end

  assign beat_hit     = (state == R) && rvalid && (rid == id_q);

  assign data_addr_ok = grant_any && grant_data;
  assign inst_addr_ok = grant_any && !grant_data;
  assign data_data_ok = beat_hit && sel_data;
  assign inst_data_ok = beat_hit && !sel_data;
  assign data_rdata   = data_data_ok ? rdata : 32'd0;
  assign inst_rdata   = inst_data_ok ? rdata : 32'd0;

  assign arvalid = (state == AR);
  assign rready  = (state == R);
  assign araddr  = addr_q;
  assign arid    = id_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      id_q      <= 4'd0;
      sel_data  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          addr_q    <= grant_data ? data_addr : inst_addr;
          id_q      <= grant_data ? DATA_ID : INST_ID;
          sel_data  <= grant_data;
`ifdef ARB_ROUND_ROBIN_EN
          last_data <= grant_data;
`endif
          state     <= AR;
        end
        AR:      if (arready) state <= R;
        // Beats with a foreign rid are accepted via rready and simply dropped.
        R:       if (beat_hit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_rd_arbiter.sv
// tb/tb_cpu_axi_rd_arbiter.sv - directed and randomized transaction-level bench
// Honours ARB_ROUND_ROBIN_EN in its tie-break expectations.
module tb_cpu_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;

  int npass = 0;
  int total = 0;
  bit last_data_m = 1'b0;

  always #5 clk = ~clk;

  cpu_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Winner selection from the arbitration rules: a lone requester wins; a tie goes
  // to data (fixed) or to the side not granted last (round-robin).
  function automatic bit pick_data(bit ir, bit dr);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_data_m;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic run_txn(input bit ir, input bit dr, input logic [31:0] ia, input logic [31:0] da,
                         input int arw, input int nstray, input logic [3:0] srid_in,
                         input bit rand_srid, input logic [31:0] rd);
    bit          sd;
    logic [3:0]  id;
    logic [31:0] a;
    logic [3:0]  srid;
    sd = pick_data(ir, dr);
    id = sd ? 4'd1 : 4'd0;
    a  = sd ? da : ia;
    inst_req = ir; data_req = dr; inst_addr = ia; data_addr = da;
    arready = (arw == 0); rvalid = 1'b0;
    @(negedge clk);
    chk("inst_addr_ok_grant", inst_addr_ok, !sd);
    chk("data_addr_ok_grant", data_addr_ok, sd);
    chk("arvalid_idle", arvalid, 0);
    chk("rready_idle", rready, 0);
    last_data_m = sd;
    @(posedge clk); #1;
    if (sd) data_req = 1'b0; else inst_req = 1'b0;
    for (int k = 0; k <= arw; k++) begin
      if (k == arw) arready = 1'b1;
      @(negedge clk);
      chk("arvalid_ar", arvalid, 1);
      chk("araddr_ar", araddr, a);
      chk("arid_ar", arid, id);
      chk("rready_ar", rready, 0);
      chk("addr_ok_ar", inst_addr_ok | data_addr_ok, 0);
      chk("data_ok_ar", inst_data_ok | data_data_ok, 0);
      chk("ar_consts", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'b01});
      @(posedge clk); #1;
    end
    arready = 1'b0;
    for (int s = 0; s < nstray; s++) begin
      srid = rand_srid ? 4'($urandom) : srid_in;
      if (srid == id) srid = srid + 4'd1;
      rvalid = 1'b1; rid = srid; rdata = $urandom;
      @(negedge clk);
      chk("rready_r", rready, 1);
      chk("data_ok_stray", inst_data_ok | data_data_ok, 0);
      chk("addr_ok_r", inst_addr_ok | data_addr_ok, 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rid = id; rdata = rd;
    @(negedge clk);
    chk("inst_data_ok", inst_data_ok, !sd);
    chk("data_data_ok", data_data_ok, sd);
    chk("rdata_out", sd ? data_rdata : inst_rdata, rd);
    chk("addr_ok_beat", inst_addr_ok | data_addr_ok, 0);
    @(posedge clk); #1;
    rvalid = 1'b0; rid = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    inst_addr = 32'h1234; data_addr = 32'h5678;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;

    run_txn(1, 0, 32'hBFC00000, 32'h0, 0, 0, 4'd0, 0, 32'h3C1DBFC0);

    run_txn(1, 1, 32'h100, 32'h200, 0, 0, 4'd0, 0, 32'hA5A50001);
    run_txn(1, 0, 32'h100, 32'h200, 0, 0, 4'd0, 0, 32'hA5A50002);
    run_txn(1, 1, 32'h104, 32'h204, 0, 0, 4'd0, 0, 32'hA5A50003);
    run_txn(1, 1, 32'h108, 32'h208, 0, 0, 4'd0, 0, 32'hA5A50004);

    run_txn(1, 1, 32'h300, 32'h400, 5, 0, 4'd0, 0, 32'h0BADF00D);

    run_txn(0, 1, 32'h0, 32'h200, 0, 1, 4'd5, 0, 32'hDEADBEEF);

    for (int t = 0; t < 25; t++) begin
      bit ir, dr;
      ir = 1'($urandom);
      dr = 1'($urandom);
      if (!ir && !dr) ir = 1'b1;
      run_txn(ir, dr, $urandom, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 4'd0, 1, $urandom);
    end

    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h300; arready = 1'b1;
    @(negedge clk);
    chk("rst_seq_grant", data_addr_ok, 1);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    chk("rst_seq_in_r", rready, 1);
    #2 rst = 1'b1; inst_req = 1'b1;
    #1;
    chk("midr_rst_arvalid", arvalid, 0);
    chk("midr_rst_rready", rready, 0);
    chk("midr_rst_araddr", araddr, 0);
    chk("midr_rst_arid", arid, 0);
    chk("midr_rst_addr_ok", inst_addr_ok | data_addr_ok, 0);
    @(posedge clk); #1;
    rst = 1'b0; inst_req = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("post_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("post_rst_rready", rready, 0);
    chk("post_rst_arvalid", arvalid, 0);
    chk("post_rst_addr_ok", inst_addr_ok | data_addr_ok, 0);
    @(posedge clk); #1;
    rvalid = 1'b0; rid = 4'd0;
    last_data_m = 1'b0;

    run_txn(1, 1, 32'h500, 32'h600, 1, 1, 4'd0, 1, 32'h13572468);

    inst_req = 1'b0; data_req = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
